// File: rtl/freq_generator_pkg.sv
// Shared constants and state encoding for the programmable square-wave generator.
package freq_generator_pkg;

    localparam int CLK_HZ_DEF = 100_000_000;
    localparam int FREQ_W_DEF = 16;
    localparam int HP_W_DEF   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_PEND = 2'd2,
        ST_RUN  = 2'd3
    } state_e;

endpackage

// File: rtl/freq_gen_divider.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, done pulses with the result.
module freq_gen_divider #(
    parameter int DVD_W = 32,
    parameter int DVS_W = 17
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVD_W-1:0] quotient,
    output logic             done
);
    localparam int CNT_W = $clog2(DVD_W + 1);

    logic [DVS_W-1:0] rem_q, rem_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [DVD_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] bits_q, bits_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [DVS_W:0]   trial;
    logic [DVS_W:0]   diff;

    always_comb begin
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        quo_d  = quo_q;
        bits_d = bits_q;
        busy_d = busy_q;
        done_d = 1'b0;
        // Quotient register doubles as the dividend shift register.
        trial  = {rem_q, quo_q[DVD_W-1]};
        diff   = trial - {1'b0, dvs_q};
        if (start) begin
            rem_d  = '0;
            dvs_d  = divisor;
            quo_d  = dividend;
            bits_d = CNT_W'(DVD_W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (trial >= {1'b0, dvs_q}) begin
                rem_d = diff[DVS_W-1:0];
                quo_d = {quo_q[DVD_W-2:0], 1'b1};
            end else begin
                rem_d = trial[DVS_W-1:0];
                quo_d = {quo_q[DVD_W-2:0], 1'b0};
            end
            bits_d = bits_q - CNT_W'(1);
            if (bits_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rem_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            bits_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            quo_q  <= quo_d;
            bits_q <= bits_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/freq_generator.sv
// Programmable square-wave source: converts a frequency request to a half-period and toggles OUT.
module freq_generator
    import freq_generator_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEF,
    parameter int FREQ_W = FREQ_W_DEF,
    parameter int HP_W   = HP_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [FREQ_W-1:0] freq_in,
    input  logic              freq_valid,
    output logic              freq_ready,
    output logic              OUT,
    output logic              active,
    output logic [FREQ_W-1:0] cur_freq
);
    localparam logic [HP_W-1:0] CLK_HZ_X = HP_W'(CLK_HZ);

    state_e            state_q, state_d;
    logic              out_q, out_d;
    logic              active_q, active_d;
    logic [HP_W-1:0]   cnt_q, cnt_d;
    logic [HP_W-1:0]   half_q, half_d;
    logic [HP_W-1:0]   pend_q, pend_d;
    logic [FREQ_W-1:0] req_q, req_d;
    logic [FREQ_W-1:0] cur_q, cur_d;

    logic              accept;
    logic              div_start;
    logic              div_done;
    logic [HP_W-1:0]   quo;
    logic [HP_W-1:0]   half_new;
    logic              toggle;

    assign freq_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign accept     = freq_valid && freq_ready;
    assign div_start  = accept && (freq_in != '0);
    assign half_new   = (quo == '0) ? HP_W'(1) : quo;
    assign toggle     = active_q && (cnt_q == half_q - HP_W'(1));

    freq_gen_divider #(
        .DVD_W(HP_W),
        .DVS_W(FREQ_W + 1)
    ) u_div (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .start    (div_start),
        .dividend (CLK_HZ_X),
        .divisor  ({freq_in, 1'b0}),
        .quotient (quo),
        .done     (div_done)
    );

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        half_d   = half_q;
        pend_d   = pend_q;
        req_d    = req_q;
        cur_d    = cur_q;

        // The wave keeps running on the old half-period while a new one is being computed.
        if (active_q) begin
            if (toggle) begin
                out_d = ~out_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + HP_W'(1);
            end
        end

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (accept) begin
                    if (freq_in == '0) begin
                        state_d  = ST_IDLE;
                        out_d    = 1'b0;
                        active_d = 1'b0;
                        cnt_d    = '0;
                        cur_d    = '0;
                    end else begin
                        req_d   = freq_in;
                        state_d = ST_DIV;
                    end
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    if (active_q) begin
                        pend_d  = half_new;
                        state_d = ST_PEND;
                    end else begin
                        out_d    = 1'b1;
                        active_d = 1'b1;
                        cnt_d    = '0;
                        half_d   = half_new;
                        cur_d    = req_q;
                        state_d  = ST_RUN;
                    end
                end
            end
            ST_PEND: begin
                // Swap only on a toggle so no runt level is produced.
                if (toggle) begin
                    half_d  = pend_q;
                    cur_d   = req_q;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            out_q    <= 1'b0;
            active_q <= 1'b0;
            cnt_q    <= '0;
            half_q   <= '0;
            pend_q   <= '0;
            req_q    <= '0;
            cur_q    <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            pend_q   <= pend_d;
            req_q    <= req_d;
            cur_q    <= cur_d;
        end
    end

    assign OUT      = out_q;
    assign active   = active_q;
    assign cur_freq = cur_q;

endmodule

// File: tb/tb_freq_generator.sv
// Bench for freq_generator: behavioural waveform model checked every cycle plus directed level timing.
module tb_freq_generator;
    localparam int CLK_HZ = 1000;
    localparam int FREQ_W = 16;
    localparam int HP_W   = 32;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b1;
    logic [FREQ_W-1:0] freq_in = '0;
    logic              freq_valid = 1'b0;
    logic              freq_ready;
    logic              OUT;
    logic              active;
    logic [FREQ_W-1:0] cur_freq;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 0;

    freq_generator #(
        .CLK_HZ(CLK_HZ),
        .FREQ_W(FREQ_W),
        .HP_W  (HP_W)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .freq_in   (freq_in),
        .freq_valid(freq_valid),
        .freq_ready(freq_ready),
        .OUT       (OUT),
        .active    (active),
        .cur_freq  (cur_freq)
    );

    always #5 CLK = ~CLK;

    function automatic int half_of(input int f);
        int h;
        h = CLK_HZ / (2 * f);
        return (h < 1) ? 1 : h;
    endfunction

    // Behavioural model: cycles left in the current level, plus a busy window while the divide runs.
    logic              m_out = 0, m_active = 0, m_busy = 0, m_pend = 0, m_acc;
    logic [FREQ_W-1:0] m_cur = 0, m_req = 0;
    int                m_left = 0, m_half = 1, m_pend_half = 1, m_div_left = 0;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_out = 0; m_active = 0; m_busy = 0; m_pend = 0;
            m_cur = 0; m_left = 0; m_half = 1; m_div_left = 0;
        end else begin
            m_acc = freq_valid && !m_busy;
            if (m_active) begin
                if (m_left <= 1) begin
                    m_out = !m_out;
                    if (m_pend) begin
                        m_half = m_pend_half; m_cur = m_req; m_pend = 0; m_busy = 0;
                    end
                    m_left = m_half;
                end else begin
                    m_left--;
                end
            end
            if (m_acc) begin
                if (freq_in == 0) begin
                    m_out = 0; m_active = 0; m_cur = 0;
                end else begin
                    m_req = freq_in; m_busy = 1; m_div_left = HP_W + 1;
                end
            end else if (m_busy && !m_pend) begin
                m_div_left--;
                if (m_div_left == 0) begin
                    if (m_active) begin
                        m_pend = 1; m_pend_half = half_of(int'(m_req));
                    end else begin
                        m_half = half_of(int'(m_req)); m_left = m_half;
                        m_out = 1; m_active = 1; m_cur = m_req; m_busy = 0;
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            n_vec++;
            if (OUT !== m_out || active !== m_active || freq_ready !== !m_busy || cur_freq !== m_cur) begin
                n_bad++;
                $display("FAIL cycle_model t=%0t OUT=%b want %b active=%b want %b ready=%b want %b cur=%0d want %0d",
                         $time, OUT, m_out, active, m_active, freq_ready, !m_busy, cur_freq, m_cur);
            end
        end
    end

    task automatic check(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic request(input int f);
        bit acc = 0;
        for (int i = 0; i < 1000 && !acc; i++) begin
            @(negedge CLK);
            freq_in = FREQ_W'(f);
            freq_valid = 1'b1;
            if (freq_ready) acc = 1;
        end
        @(negedge CLK);
        freq_valid = 1'b0;
        if (!acc) begin
            n_vec++; n_bad++;
            $display("FAIL request_timeout f=%0d ready stayed 0, expected 1", f);
        end
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!freq_ready && n < 2000) begin n++; @(negedge CLK); end
        check(nm, freq_ready, 1);
    endtask

    task automatic count_level(input logic lvl, output int len);
        len = 0;
        while (OUT === lvl && len < 5000) begin len++; @(negedge CLK); end
    endtask

    task automatic scen_250(input string tag);
        int lo, h1, l1;
        request(250);
        lo = 0;
        while (!freq_ready && lo < 200) begin lo++; @(negedge CLK); end
        check({tag, "_ready_low"}, lo, HP_W + 1);
        check({tag, "_out_start"}, OUT, 1);
        check({tag, "_active"}, active, 1);
        check({tag, "_cur"}, cur_freq, 250);
        count_level(1'b1, h1);
        check({tag, "_high"}, h1, 2);
        count_level(1'b0, l1);
        check({tag, "_low"}, l1, 2);
    endtask

    initial begin
        int a, b, c, run, bad, nruns, guard, r, f;
        logic prev;
        bit first;

        #3 RST_N = 1'b0;
        #1;
        chk_en = 1;
        check("rst_out", OUT, 0);
        check("rst_active", active, 0);
        check("rst_ready", freq_ready, 1);
        check("rst_cur", cur_freq, 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        scen_250("f250");

        request(3);
        wait_ready("f3_ready");
        count_level(OUT, a); check("f3_level_a", a, 166);
        count_level(OUT, b); check("f3_level_b", b, 166);

        request(600);
        wait_ready("f600_ready");
        count_level(OUT, a); check("f600_level_a", a, 1);
        count_level(OUT, b); check("f600_level_b", b, 1);
        count_level(OUT, c); check("f600_level_c", c, 1);

        request(250);
        wait_ready("f250b_ready");
        request(100);
        prev = OUT; run = 0; first = 1; bad = 0; nruns = 0; guard = 0;
        while (!freq_ready && guard < 500) begin
            @(negedge CLK);
            guard++;
            if (OUT !== prev) begin
                if (!first) begin nruns++; if (run != 2) bad++; end
                first = 0; run = 1; prev = OUT;
            end else begin
                run++;
            end
        end
        check("f100_old_phases_bad", bad, 0);
        check("f100_old_phases_seen", nruns > 0, 1);
        check("f100_cur", cur_freq, 100);
        count_level(OUT, a); check("f100_level_a", a, 5);
        count_level(OUT, b); check("f100_level_b", b, 5);

        request(0);
        check("stop_out", OUT, 0);
        check("stop_active", active, 0);
        check("stop_cur", cur_freq, 0);
        check("stop_ready", freq_ready, 1);

        request(250);
        repeat (10) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("middiv_rst_out", OUT, 0);
        check("middiv_rst_active", active, 0);
        check("middiv_rst_ready", freq_ready, 1);
        check("middiv_rst_cur", cur_freq, 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        scen_250("after_rst");

        for (int i = 0; i < 5000; i++) begin
            @(negedge CLK);
            if (i == 2500) begin
                #3 RST_N = 1'b0;
                @(negedge CLK);
                RST_N = 1'b1;
            end
            r = $urandom_range(0, 9);
            if (r == 0)      f = 0;
            else if (r < 3)  f = $urandom_range(1, 20);
            else if (r < 5)  f = $urandom_range(400, 2000);
            else if (r == 9) f = 16'hFFFF;
            else             f = $urandom_range(21, 400);
            freq_in = FREQ_W'(f);
            freq_valid = ($urandom_range(0, 15) == 0);
        end
        @(negedge CLK);
        freq_valid = 1'b0;
        repeat (5) @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
